// File: rtl/md_extract.sv
// md_extract: header-extraction stage ahead of metadata processing.
//
// Parses the first 256-bit beat of each Ethernet frame into a 128-bit metadata
// word. That word is driven on m_axis_tuser for every beat of the packet.
// tdata/tkeep/tlast pass through unchanged.
// The output is registered and backed by a one-entry skid buffer. This gives
// full throughput without a combinational path from m_axis_tready to
// s_axis_tready.
//
// Ports
//   clk, aresetn          clock; synchronous active-low reset
//   s_axis_t*             input stream; tuser[15:0] = packet length (first beat)
//   m_axis_t*             output stream; tuser = metadata word
//
// Metadata word
//   [15:0]  len         [31:16] ethertype    [39:32] ip proto (ipv4 only)
//   [71:40] ipv4 src    [72]    ipv4         [73]    single-beat packet
//   [95:80] seq         others  zero
//
// Build option MD_EXTRACT_DROP_RUNT_EN: when defined, a single-beat packet
// shorter than 14 bytes (tkeep[13]=0) is accepted and silently discarded, and
// seq does not advance. When undefined, such runts are forwarded normally.

module md_extract #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128
) (
  input  logic                              clk,
  input  logic                              aresetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast
);

  localparam int DW = C_S_AXIS_DATA_WIDTH;
  localparam int KW = C_S_AXIS_DATA_WIDTH / 8;
  localparam int UW = C_S_AXIS_TUSER_WIDTH;

  localparam logic [0:0] ST_FIRST = 1'b0;
  localparam logic [0:0] ST_BODY  = 1'b1;

  logic [0:0]     state;
  logic [15:0]    seq;
  logic [UW-1:0]  md_hold;

  // Skid entry
  logic           skid_valid;
  logic [DW-1:0]  skid_data;
  logic [KW-1:0]  skid_keep;
  logic [UW-1:0]  skid_user;
  logic           skid_last;

  // Only the length field of the incoming tuser is used.
  logic unused_tuser;
  assign unused_tuser = ^s_axis_tuser[UW-1:16];

  // Byte view with disabled lanes forced to zero, so fields taken from a
  // short first beat never pick up stale data.
  logic [KW-1:0][7:0] byte_m;
  for (genvar k = 0; k < KW; k++) begin : g_byte
    assign byte_m[k] = s_axis_tkeep[k] ? s_axis_tdata[8*k +: 8] : 8'h00;
  end

  logic [15:0]   ethertype;
  logic          is_ipv4;
  logic [7:0]    ip_proto;
  logic [31:0]   ip_src;
  logic [UW-1:0] md_new;
  logic [UW-1:0] in_user;

  assign ethertype = {byte_m[12], byte_m[13]};
  assign is_ipv4   = (ethertype == 16'h0800) && s_axis_tkeep[29];
  assign ip_proto  = is_ipv4 ? byte_m[23] : 8'h00;
  assign ip_src    = is_ipv4 ? {byte_m[26], byte_m[27], byte_m[28], byte_m[29]} : 32'h0;

  always_comb begin
    md_new         = '0;
    md_new[15:0]   = s_axis_tuser[15:0];
    md_new[31:16]  = ethertype;
    md_new[39:32]  = ip_proto;
    md_new[71:40]  = ip_src;
    md_new[72]     = is_ipv4;
    md_new[73]     = s_axis_tlast;
    md_new[95:80]  = seq;
  end

  // A first beat carries freshly computed metadata.
  // Later beats reuse the latched copy.
  assign in_user = (state == ST_FIRST) ? md_new : md_hold;

  logic accept;
  logic drop;
  logic fwd;
  logic out_ready;

  assign accept = s_axis_tvalid && s_axis_tready;

`ifdef MD_EXTRACT_DROP_RUNT_EN
  assign drop = (state == ST_FIRST) && s_axis_tlast && !s_axis_tkeep[13];
`else
  assign drop = 1'b0;
`endif

  assign fwd       = accept && !drop;
  assign out_ready = !m_axis_tvalid || m_axis_tready;

  // Next skid occupancy. s_axis_tready is registered from it.
  logic skid_valid_nxt;
  always_comb begin
    skid_valid_nxt = skid_valid;
    if (out_ready)
      skid_valid_nxt = 1'b0;
    else if (fwd)
      skid_valid_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state         <= ST_FIRST;
      seq           <= 16'h0;
      md_hold       <= '0;
      skid_valid    <= 1'b0;
      skid_data     <= '0;
      skid_keep     <= '0;
      skid_user     <= '0;
      skid_last     <= 1'b0;
      s_axis_tready <= 1'b1;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      // Packet framing; advances only on accepted beats.
      if (accept) begin
        if (state == ST_FIRST) begin
          if (!drop) begin
            md_hold <= md_new;
            seq     <= seq + 16'd1;
          end
          if (!s_axis_tlast)
            state <= ST_BODY;
        end else if (s_axis_tlast) begin
          state <= ST_FIRST;
        end
      end

      // Output register, loaded from the skid entry first to keep order.
      // While skid is occupied, s_axis_tready is low, so no new beat competes.
      if (out_ready) begin
        if (skid_valid) begin
          m_axis_tvalid <= 1'b1;
          m_axis_tdata  <= skid_data;
          m_axis_tkeep  <= skid_keep;
          m_axis_tuser  <= skid_user;
          m_axis_tlast  <= skid_last;
        end else if (fwd) begin
          m_axis_tvalid <= 1'b1;
          m_axis_tdata  <= s_axis_tdata;
          m_axis_tkeep  <= s_axis_tkeep;
          m_axis_tuser  <= in_user;
          m_axis_tlast  <= s_axis_tlast;
        end else begin
          m_axis_tvalid <= 1'b0;
        end
      end else if (fwd) begin
        skid_data <= s_axis_tdata;
        skid_keep <= s_axis_tkeep;
        skid_user <= in_user;
        skid_last <= s_axis_tlast;
      end

      skid_valid    <= skid_valid_nxt;
      s_axis_tready <= !skid_valid_nxt;
    end
  end

endmodule

// File: tb/tb_md_extract.sv
// Directed bench for md_extract. Inputs change on the falling edge.
// Outputs are checked on the falling edge, so each check sees the state
// left by the preceding rising edge.
module tb_md_extract;

  logic         clk = 1'b0;
  logic         aresetn;
  logic [255:0] s_tdata;
  logic [31:0]  s_tkeep;
  logic [127:0] s_tuser;
  logic         s_tvalid;
  logic         s_tready;
  logic         s_tlast;
  logic [255:0] m_tdata;
  logic [31:0]  m_tkeep;
  logic [127:0] m_tuser;
  logic         m_tvalid;
  logic         m_tready;
  logic         m_tlast;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  md_extract dut (
    .clk(clk), .aresetn(aresetn),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tuser(m_tuser),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [255:0] d, input logic [31:0] k,
                         input logic [127:0] u, input logic l);
    chk({tag, "_valid"}, 256'(m_tvalid), 256'd1);
    chk({tag, "_data"},  m_tdata, d);
    chk({tag, "_keep"},  256'(m_tkeep), 256'(k));
    chk({tag, "_user"},  256'(m_tuser), 256'(u));
    chk({tag, "_last"},  256'(m_tlast), 256'(l));
  endtask

  task automatic drive(input logic v, input logic [255:0] d, input logic [31:0] k,
                       input logic [127:0] u, input logic l);
    s_tvalid = v; s_tdata = d; s_tkeep = k; s_tuser = u; s_tlast = l;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    aresetn = 1'b0;
    idle();
    @(negedge clk);
    aresetn = 1'b1;
  endtask

  // Frame filler: byte k = tag+k, then header fields placed at their offsets.
  function automatic logic [255:0] mk_frame(input logic [15:0] et, input logic [7:0] pr,
                                            input logic [31:0] src, input logic [7:0] tag);
    logic [255:0] f;
    for (int k = 0; k < 32; k++) f[8*k +: 8] = tag + 8'(k);
    f[8*12 +: 8] = et[15:8];
    f[8*13 +: 8] = et[7:0];
    f[8*23 +: 8] = pr;
    f[8*26 +: 8] = src[31:24];
    f[8*27 +: 8] = src[23:16];
    f[8*28 +: 8] = src[15:8];
    f[8*29 +: 8] = src[7:0];
    return f;
  endfunction

  logic [255:0] f0, f1, f2, f3;
  logic [127:0] md;

  initial begin
    aresetn  = 1'b0;
    m_tready = 1'b1;
    idle();
    @(negedge clk);
    @(negedge clk);
    aresetn = 1'b1;

    // Reset state
    chk("rst_mvalid", 256'(m_tvalid), 256'd0);
    chk("rst_sready", 256'(s_tready), 256'd1);
    chk("rst_tdata",  m_tdata, 256'd0);
    chk("rst_tkeep",  256'(m_tkeep), 256'd0);
    chk("rst_tuser",  256'(m_tuser), 256'd0);
    chk("rst_tlast",  256'(m_tlast), 256'd0);

    // 1: IPv4/UDP, 3 beats, seq 0
    f0 = mk_frame(16'h0800, 8'h11, 32'h0A000001, 8'h10);
    f1 = mk_frame(16'h1234, 8'h55, 32'h11223344, 8'h20);
    f2 = mk_frame(16'h4321, 8'h66, 32'h55667788, 8'h30);
    md = {32'h0, 16'h0000, 8'h01, 32'h0A000001, 8'h11, 16'h0800, 16'd80};
    drive(1'b1, f0, 32'hFFFFFFFF, 128'd80, 1'b0);
    @(negedge clk);
    chk_out("t1_b0", f0, 32'hFFFFFFFF, md, 1'b0);
    drive(1'b1, f1, 32'hFFFFFFFF, 128'hDEAD, 1'b0);
    @(negedge clk);
    chk_out("t1_b1", f1, 32'hFFFFFFFF, md, 1'b0);
    drive(1'b1, f2, 32'h0000FFFF, 128'hBEEF, 1'b1);
    @(negedge clk);
    chk_out("t1_b2", f2, 32'h0000FFFF, md, 1'b1);
    idle();
    @(negedge clk);
    chk("t1_idle", 256'(m_tvalid), 256'd0);

    // 2: two back-to-back single-beat ARP packets, seq 0 then 1
    do_reset();
    f0 = mk_frame(16'h0806, 8'h22, 32'hC0A80101, 8'h40);
    f1 = mk_frame(16'h0806, 8'h33, 32'hC0A80102, 8'h50);
    drive(1'b1, f0, 32'hFFFFFFFF, 128'd60, 1'b1);
    @(negedge clk);
    chk_out("t2_p0", f0, 32'hFFFFFFFF, {32'h0, 16'h0000, 8'h02, 32'h0, 8'h00, 16'h0806, 16'd60}, 1'b1);
    drive(1'b1, f1, 32'hFFFFFFFF, 128'd64, 1'b1);
    @(negedge clk);
    chk_out("t2_p1", f1, 32'hFFFFFFFF, {32'h0, 16'h0001, 8'h02, 32'h0, 8'h00, 16'h0806, 16'd64}, 1'b1);
    idle();
    @(negedge clk);
    chk("t2_idle", 256'(m_tvalid), 256'd0);

    // 3: 4-beat packet, downstream ready 1,0,0,1; seq 2
    f0 = mk_frame(16'h86DD, 8'h44, 32'h01020304, 8'h60);
    f1 = mk_frame(16'h0001, 8'h01, 32'h0, 8'h61);
    f2 = mk_frame(16'h0002, 8'h02, 32'h0, 8'h62);
    f3 = mk_frame(16'h0003, 8'h03, 32'h0, 8'h63);
    md = {32'h0, 16'd2, 8'h00, 32'h0, 8'h00, 16'h86DD, 16'd200};
    drive(1'b1, f0, 32'hFFFFFFFF, 128'd200, 1'b0);
    @(negedge clk);
    chk_out("t3_b0", f0, 32'hFFFFFFFF, md, 1'b0);
    drive(1'b1, f1, 32'hFFFFFFFF, 128'd0, 1'b0);
    m_tready = 1'b1;
    @(negedge clk);
    chk_out("t3_b1", f1, 32'hFFFFFFFF, md, 1'b0);
    chk("t3_sready_pre", 256'(s_tready), 256'd1);
    drive(1'b1, f2, 32'hFFFFFFFF, 128'd0, 1'b0);
    m_tready = 1'b0;
    @(negedge clk);
    chk_out("t3_stall1", f1, 32'hFFFFFFFF, md, 1'b0);
    chk("t3_sready_drop", 256'(s_tready), 256'd0);
    drive(1'b1, f3, 32'hFFFFFFFF, 128'd0, 1'b1);
    m_tready = 1'b0;
    @(negedge clk);
    chk_out("t3_stall2", f1, 32'hFFFFFFFF, md, 1'b0);
    chk("t3_sready_low", 256'(s_tready), 256'd0);
    m_tready = 1'b1;
    @(negedge clk);
    chk_out("t3_b2", f2, 32'hFFFFFFFF, md, 1'b0);
    chk("t3_sready_back", 256'(s_tready), 256'd1);
    @(negedge clk);
    chk_out("t3_b3", f3, 32'hFFFFFFFF, md, 1'b1);
    idle();
    @(negedge clk);
    chk("t3_idle", 256'(m_tvalid), 256'd0);

    // IPv4 ethertype but tkeep[29]=0: not flagged ipv4, proto/src zero; seq 3
    f0 = mk_frame(16'h0800, 8'h06, 32'hAC100001, 8'h70);
    drive(1'b1, f0, 32'h1FFFFFFF, 128'd29, 1'b1);
    @(negedge clk);
    chk_out("tk29", f0, 32'h1FFFFFFF, {32'h0, 16'd3, 8'h02, 32'h0, 8'h00, 16'h0800, 16'd29}, 1'b1);
    idle();

    // 4: seq wrap FFFF -> 0000
    @(negedge clk);
    force dut.seq = 16'hFFFF;
    @(negedge clk);
    release dut.seq;
    f0 = mk_frame(16'h0800, 8'h01, 32'h08080808, 8'h80);
    f1 = mk_frame(16'h0800, 8'h01, 32'h08080808, 8'h90);
    drive(1'b1, f0, 32'hFFFFFFFF, 128'd98, 1'b1);
    @(negedge clk);
    chk_out("t4_p0", f0, 32'hFFFFFFFF, {32'h0, 16'hFFFF, 8'h03, 32'h08080808, 8'h01, 16'h0800, 16'd98}, 1'b1);
    drive(1'b1, f1, 32'hFFFFFFFF, 128'd98, 1'b1);
    @(negedge clk);
    chk_out("t4_p1", f1, 32'hFFFFFFFF, {32'h0, 16'h0000, 8'h03, 32'h08080808, 8'h01, 16'h0800, 16'd98}, 1'b1);
    idle();
    @(negedge clk);

    // 5: reset during beat 2 of a 4-beat packet, then a fresh packet
    f0 = mk_frame(16'h0800, 8'h11, 32'h01010101, 8'hB0);
    f1 = mk_frame(16'h0000, 8'h00, 32'h0, 8'hB1);
    f2 = mk_frame(16'h0000, 8'h00, 32'h0, 8'hB2);
    drive(1'b1, f0, 32'hFFFFFFFF, 128'd300, 1'b0);
    @(negedge clk);
    drive(1'b1, f1, 32'hFFFFFFFF, 128'd0, 1'b0);
    @(negedge clk);
    aresetn = 1'b0;
    drive(1'b1, f2, 32'hFFFFFFFF, 128'd0, 1'b0);
    @(negedge clk);
    chk("t5_mvalid", 256'(m_tvalid), 256'd0);
    chk("t5_sready", 256'(s_tready), 256'd1);
    chk("t5_tuser",  256'(m_tuser), 256'd0);
    aresetn = 1'b1;
    f3 = mk_frame(16'h0806, 8'h77, 32'hFFFFFFFF, 8'hC0);
    drive(1'b1, f3, 32'hFFFFFFFF, 128'd42, 1'b1);
    @(negedge clk);
    chk_out("t5_new", f3, 32'hFFFFFFFF, {32'h0, 16'h0000, 8'h02, 32'h0, 8'h00, 16'h0806, 16'd42}, 1'b1);
    idle();
    @(negedge clk);

    // 6: 10-byte single-beat runt; ethertype bytes lie beyond tkeep
    f0 = mk_frame(16'h0800, 8'h11, 32'h0A000001, 8'hA0);
    drive(1'b1, f0, 32'h000003FF, 128'd10, 1'b1);
    @(negedge clk);
`ifdef MD_EXTRACT_DROP_RUNT_EN
    chk("t6_dropped", 256'(m_tvalid), 256'd0);
    chk("t6_sready",  256'(s_tready), 256'd1);
`else
    chk_out("t6_runt", f0, 32'h000003FF, {32'h0, 16'h0001, 8'h02, 32'h0, 8'h00, 16'h0000, 16'd10}, 1'b1);
`endif
    f1 = mk_frame(16'h0806, 8'h00, 32'h0, 8'hD0);
    drive(1'b1, f1, 32'hFFFFFFFF, 128'd60, 1'b1);
    @(negedge clk);
`ifdef MD_EXTRACT_DROP_RUNT_EN
    chk_out("t6_next", f1, 32'hFFFFFFFF, {32'h0, 16'h0001, 8'h02, 32'h0, 8'h00, 16'h0806, 16'd60}, 1'b1);
`else
    chk_out("t6_next", f1, 32'hFFFFFFFF, {32'h0, 16'h0002, 8'h02, 32'h0, 8'h00, 16'h0806, 16'd60}, 1'b1);
`endif
    idle();
    @(negedge clk);
    chk("t6_idle", 256'(m_tvalid), 256'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
